// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
//   wb_sel_e : write-back source select encoding
//   F3_*     : load funct3 encodings
//   state_e  : write-back stage FSM states
package wb_pkg;

    // Write-back source select; WB_RSVD behaves as WB_ALU.
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    // Load funct3 encodings (RV32I/RV64I).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // READY accepts instructions; WAIT_MEM holds one outstanding load.
    typedef enum logic {
        READY    = 1'b0,
        WAIT_MEM = 1'b1
    } state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: selects the addressed byte/half/word/dword
// from a raw memory word and sign- or zero-extends it to DWIDTH.
//   raw_data : raw memory word
//   offset   : byte offset of the load address within the word
//   funct3   : load type
//   data     : formatted load value (don't-care when fault is set)
//   fault    : misaligned offset or funct3 not legal at this DWIDTH
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    localparam int unsigned OFFW = $clog2(DWIDTH / 8)
) (
    input  logic [DWIDTH-1:0] raw_data,
    input  logic [OFFW-1:0]   offset,
    input  logic [2:0]        funct3,
    output logic [DWIDTH-1:0] data,
    output logic              fault
);

    localparam logic IS_RV64 = (DWIDTH == 64);

    logic [DWIDTH-1:0] shifted;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       lane_w;

    // Shift the addressed byte down to bit 0, then extend by load type.
    always_comb begin
        shifted = raw_data >> {offset, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = shifted[15:0];
        lane_w  = shifted[31:0];
        data    = '0;
        fault   = 1'b0;
        case (funct3)
            F3_LB:  data = DWIDTH'($signed(lane_b));
            F3_LBU: data = DWIDTH'(lane_b);
            F3_LH: begin
                data  = DWIDTH'($signed(lane_h));
                fault = offset[0];
            end
            F3_LHU: begin
                data  = DWIDTH'(lane_h);
                fault = offset[0];
            end
            F3_LW: begin
                data  = DWIDTH'($signed(lane_w));
                fault = |offset[1:0];
            end
            F3_LWU: begin
                data  = DWIDTH'(lane_w);
                fault = !IS_RV64 || (|offset[1:0]);
            end
            F3_LD: begin
                data  = shifted;
                fault = !IS_RV64 || (offset != '0);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Registered, handshaked write-back stage between the memory stage and the
// register file. Selects ALU / formatted load / PC+4 data, stalls while a
// load response is outstanding, and counts retired instructions.
//   clk, reset        : clock, asynchronous active-low reset
//   in_valid_i/ready_o: upstream handshake
//   pc_i, alu_res_i, rd_i, regwren_i, wb_sel_i, funct3_i : instruction fields
//   flush_i           : kill in-flight load and incoming instruction
//   mem_rsp_valid_i, memory_data_i : load response
//   rf_wren_o, rf_rd_o, writeback_data_o : register-file write / forwarding
//   retire_o, load_fault_o : one-cycle commit / load-fault pulses
//   instret_o         : retired-instruction counter (wraps)
module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 32,
    parameter int unsigned RWIDTH   = 5,
    parameter int unsigned CNTWIDTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [AWIDTH-1:0]   pc_i,
    input  logic [DWIDTH-1:0]   alu_res_i,
    input  logic [RWIDTH-1:0]   rd_i,
    input  logic                regwren_i,
    input  logic [1:0]          wb_sel_i,
    input  logic [2:0]          funct3_i,
    input  logic                flush_i,
    input  logic                mem_rsp_valid_i,
    input  logic [DWIDTH-1:0]   memory_data_i,
    output logic                rf_wren_o,
    output logic [RWIDTH-1:0]   rf_rd_o,
    output logic [DWIDTH-1:0]   writeback_data_o,
    output logic                retire_o,
    output logic                load_fault_o,
    output logic [CNTWIDTH-1:0] instret_o
);

    localparam int unsigned OFFW = $clog2(DWIDTH / 8);

    state_e              state_q;
    logic [RWIDTH-1:0]   ld_rd_q;
    logic                ld_wren_q;
    logic [2:0]          ld_funct3_q;
    logic [OFFW-1:0]     ld_off_q;

    wb_sel_e             sel_c;
    logic                accept_c;
    logic [AWIDTH-1:0]   pc_plus4_c;
    logic [DWIDTH-1:0]   direct_data_c;
    logic [DWIDTH-1:0]   load_data_c;
    logic                load_fault_c;

    logic                commit_c;
    logic                fault_c;
    logic [RWIDTH-1:0]   commit_rd_c;
    logic                commit_we_c;
    logic [DWIDTH-1:0]   commit_data_c;

    assign in_ready_o = (state_q == READY);
    assign accept_c   = in_valid_i & in_ready_o & ~flush_i;
    assign sel_c      = wb_sel_e'(wb_sel_i);

    // PC+4 wraps at AWIDTH, then is zero-extended or truncated to DWIDTH.
    assign pc_plus4_c    = pc_i + AWIDTH'(4);
    assign direct_data_c = (sel_c == WB_PC4) ? DWIDTH'(pc_plus4_c) : alu_res_i;

    // Formats the response of the outstanding load using captured fields.
    load_align #(
        .DWIDTH (DWIDTH)
    ) u_load_align (
        .raw_data (memory_data_i),
        .offset   (ld_off_q),
        .funct3   (ld_funct3_q),
        .data     (load_data_c),
        .fault    (load_fault_c)
    );

    // Decide whether this edge commits, faults, or does neither.
    always_comb begin
        commit_c      = 1'b0;
        fault_c       = 1'b0;
        commit_rd_c   = rd_i;
        commit_we_c   = regwren_i;
        commit_data_c = direct_data_c;
        case (state_q)
            READY: commit_c = accept_c && (sel_c != WB_MEM);
            WAIT_MEM: begin
                // A flush in the same cycle as the response discards it.
                if (mem_rsp_valid_i && !flush_i) begin
                    commit_c      = !load_fault_c;
                    fault_c       = load_fault_c;
                    commit_rd_c   = ld_rd_q;
                    commit_we_c   = ld_wren_q;
                    commit_data_c = load_data_c;
                end
            end
            default: ;
        endcase
    end

    // State, captured load context and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= READY;
            ld_rd_q          <= '0;
            ld_wren_q        <= 1'b0;
            ld_funct3_q      <= '0;
            ld_off_q         <= '0;
            rf_wren_o        <= 1'b0;
            rf_rd_o          <= '0;
            writeback_data_o <= '0;
            retire_o         <= 1'b0;
            load_fault_o     <= 1'b0;
            instret_o        <= '0;
        end else begin
            rf_wren_o    <= commit_c & commit_we_c & (commit_rd_c != '0);
            retire_o     <= commit_c;
            load_fault_o <= fault_c;
            if (commit_c) begin
                rf_rd_o          <= commit_rd_c;
                writeback_data_o <= commit_data_c;
                instret_o        <= instret_o + CNTWIDTH'(1);
            end
            case (state_q)
                READY: begin
                    if (accept_c && (sel_c == WB_MEM)) begin
                        state_q     <= WAIT_MEM;
                        ld_rd_q     <= rd_i;
                        ld_wren_q   <= regwren_i;
                        ld_funct3_q <= funct3_i;
                        ld_off_q    <= alu_res_i[OFFW-1:0];
                    end
                end
                WAIT_MEM: begin
                    if (flush_i || mem_rsp_valid_i) begin
                        state_q <= READY;
                    end
                end
                default: state_q <= READY;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases with literal
// expectations, then randomized traffic against a behavioural model. A second
// instance with a 4-bit counter exercises instret wrap-around.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [4:0]  rd;
    logic        regwren;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic        flush;
    logic        mem_rsp;
    logic [31:0] mem_data;

    logic        in_ready_o, rf_wren_o, retire_o, load_fault_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] writeback_data_o;
    logic [63:0] instret_o;

    logic        ready4, wren4, retire4, fault4;
    logic [4:0]  rd4;
    logic [31:0] data4;
    logic [3:0]  instret4;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state.
    bit          m_pending;
    logic [4:0]  p_rd;
    bit          p_we;
    int unsigned p_f3;
    int unsigned p_off;
    bit          e_wren, e_retire, e_fault;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [63:0] m_cnt;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready_o),
        .pc_i             (pc),
        .alu_res_i        (alu_res),
        .rd_i             (rd),
        .regwren_i        (regwren),
        .wb_sel_i         (wb_sel),
        .funct3_i         (funct3),
        .flush_i          (flush),
        .mem_rsp_valid_i  (mem_rsp),
        .memory_data_i    (mem_data),
        .rf_wren_o        (rf_wren_o),
        .rf_rd_o          (rf_rd_o),
        .writeback_data_o (writeback_data_o),
        .retire_o         (retire_o),
        .load_fault_o     (load_fault_o),
        .instret_o        (instret_o)
    );

    writeback_stage #(.CNTWIDTH(4)) dut4 (
        .clk              (clk),
        .reset            (reset),
        .in_valid_i       (in_valid),
        .in_ready_o       (ready4),
        .pc_i             (pc),
        .alu_res_i        (alu_res),
        .rd_i             (rd),
        .regwren_i        (regwren),
        .wb_sel_i         (wb_sel),
        .funct3_i         (funct3),
        .flush_i          (flush),
        .mem_rsp_valid_i  (mem_rsp),
        .memory_data_i    (mem_data),
        .rf_wren_o        (wren4),
        .rf_rd_o          (rd4),
        .writeback_data_o (data4),
        .retire_o         (retire4),
        .load_fault_o     (fault4),
        .instret_o        (instret4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load formatting for a 32-bit datapath.
    task automatic ref_load(input logic [31:0] w, input int unsigned off, input int unsigned f3,
                            output logic [31:0] v, output bit flt);
        logic [31:0] b;
        logic [31:0] h;
        b   = (w >> (8 * off)) & 32'h0000_00FF;
        h   = (w >> (8 * off)) & 32'h0000_FFFF;
        v   = 32'h0;
        flt = 1'b0;
        case (f3)
            0: v = b[7] ? (b | 32'hFFFF_FF00) : b;
            4: v = b;
            1: if (off % 2 != 0) flt = 1'b1; else v = h[15] ? (h | 32'hFFFF_0000) : h;
            5: if (off % 2 != 0) flt = 1'b1; else v = h;
            2: if (off != 0) flt = 1'b1; else v = w;
            default: flt = 1'b1;
        endcase
    endtask

    task automatic model_reset();
        m_pending = 1'b0;
        e_wren    = 1'b0;
        e_retire  = 1'b0;
        e_fault   = 1'b0;
        e_rd      = 5'd0;
        e_data    = 32'h0;
        m_cnt     = 64'd0;
    endtask

    task automatic model_commit(input logic [4:0] r, input bit we, input logic [31:0] val);
        e_retire = 1'b1;
        e_wren   = we && (r != 5'd0);
        e_rd     = r;
        e_data   = val;
        m_cnt    = m_cnt + 64'd1;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic [31:0] v;
        bit          flt;
        e_wren   = 1'b0;
        e_retire = 1'b0;
        e_fault  = 1'b0;
        if (!m_pending) begin
            if (in_valid && !flush) begin
                if (wb_sel == 2'b01) begin
                    m_pending = 1'b1;
                    p_rd      = rd;
                    p_we      = regwren;
                    p_f3      = int'(funct3);
                    p_off     = int'(alu_res % 32'd4);
                end else begin
                    model_commit(rd, regwren, (wb_sel == 2'b10) ? pc + 32'd4 : alu_res);
                end
            end
        end else if (flush) begin
            m_pending = 1'b0;
        end else if (mem_rsp) begin
            m_pending = 1'b0;
            ref_load(mem_data, p_off, p_f3, v, flt);
            if (flt) e_fault = 1'b1;
            else     model_commit(p_rd, p_we, v);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at negedge.
    task automatic cyc(input bit v, input logic [1:0] sel, input logic [4:0] r, input bit we,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] p,
                       input bit fl, input bit rsp, input logic [31:0] md);
        in_valid = v;   wb_sel  = sel; rd       = r;   regwren = we;
        funct3   = f3;  alu_res = alu; pc       = p;   flush   = fl;
        mem_rsp  = rsp; mem_data = md;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input bit rsp, input bit fl, input logic [31:0] md);
        cyc(1'b0, 2'b00, 5'd0, 1'b0, 3'd0, 32'h0, 32'h0, fl, rsp, md);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready",    {63'd0, in_ready_o},   {63'd0, !m_pending});
            chk("wren",     {63'd0, rf_wren_o},    {63'd0, e_wren});
            chk("retire",   {63'd0, retire_o},     {63'd0, e_retire});
            chk("fault",    {63'd0, load_fault_o}, {63'd0, e_fault});
            chk("rd",       {59'd0, rf_rd_o},      {59'd0, e_rd});
            chk("data",     {32'd0, writeback_data_o}, {32'd0, e_data});
            chk("instret",  instret_o,             m_cnt);
            chk("instret4", {60'd0, instret4},     {60'd0, m_cnt[3:0]});
        end
    end

    initial begin
        int lo_cnt;
        reset = 1'b0;
        in_valid = 1'b0; wb_sel = 2'b00; rd = 5'd0; regwren = 1'b0; funct3 = 3'd0;
        alu_res = 32'h0; pc = 32'h0; flush = 1'b0; mem_rsp = 1'b0; mem_data = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready",   {63'd0, in_ready_o}, 64'd1);
        chk("rst_wren",    {63'd0, rf_wren_o},  64'd0);
        chk("rst_retire",  {63'd0, retire_o},   64'd0);
        chk("rst_data",    {32'd0, writeback_data_o}, 64'd0);
        chk("rst_instret", instret_o, 64'd0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // ALU op, rd=5.
        cyc(1, 2'b00, 5'd5, 1, 3'd0, 32'h0000_1234, 32'h0, 0, 0, 32'h0);
        chk("t1_wren",    {63'd0, rf_wren_o}, 64'd1);
        chk("t1_rd",      {59'd0, rf_rd_o},   64'd5);
        chk("t1_data",    {32'd0, writeback_data_o}, 64'h1234);
        chk("t1_instret", instret_o, 64'd1);
        idle(0, 0, 32'h0);
        chk("t1_wren_off", {63'd0, rf_wren_o}, 64'd0);

        // Three back-to-back ALU ops.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 2'b00, 5'(6 + i), 1, 3'd0, 32'(100 + i), 32'h0, 0, 0, 32'h0);
            chk("b2b_wren",  {63'd0, rf_wren_o},  64'd1);
            chk("b2b_ready", {63'd0, in_ready_o}, 64'd1);
        end
        chk("b2b_instret", instret_o, 64'd4);

        // LB at offset 2, response three cycles after accept.
        lo_cnt = 0;
        cyc(1, 2'b01, 5'd7, 1, 3'd0, 32'h1000_0002, 32'h0, 0, 0, 32'h0);
        if (!in_ready_o) lo_cnt++;
        for (int i = 0; i < 2; i++) begin
            idle(0, 0, 32'h0);
            if (!in_ready_o) lo_cnt++;
        end
        idle(1, 0, 32'h8899_AABB);
        chk("lb_stall_cycles", 64'(lo_cnt), 64'd3);
        chk("lb_wren", {63'd0, rf_wren_o}, 64'd1);
        chk("lb_data", {32'd0, writeback_data_o}, 64'hFFFF_FF99);

        // LHU at offset 0.
        cyc(1, 2'b01, 5'd8, 1, 3'd5, 32'h2000_0000, 32'h0, 0, 0, 32'h0);
        idle(1, 0, 32'h8899_AABB);
        chk("lhu_data", {32'd0, writeback_data_o}, 64'h0000_AABB);

        // LH at offset 3 faults.
        cyc(1, 2'b01, 5'd9, 1, 3'd1, 32'h2000_0003, 32'h0, 0, 0, 32'h0);
        idle(1, 0, 32'h8899_AABB);
        chk("lh_fault",   {63'd0, load_fault_o}, 64'd1);
        chk("lh_wren",    {63'd0, rf_wren_o},    64'd0);
        chk("lh_instret", instret_o, 64'd6);

        // JAL-style PC+4.
        cyc(1, 2'b10, 5'd1, 1, 3'd0, 32'hDEAD_0000, 32'h0000_0FFC, 0, 0, 32'h0);
        chk("jal_data", {32'd0, writeback_data_o}, 64'h0000_1000);

        // rd=0 still retires.
        cyc(1, 2'b00, 5'd0, 1, 3'd0, 32'h0000_DEAD, 32'h0, 0, 0, 32'h0);
        chk("rd0_retire", {63'd0, retire_o},  64'd1);
        chk("rd0_wren",   {63'd0, rf_wren_o}, 64'd0);

        // Flush in WAIT_MEM with a same-cycle response.
        cyc(1, 2'b01, 5'd10, 1, 3'd2, 32'h3000_0000, 32'h0, 0, 0, 32'h0);
        idle(1, 1, 32'h1111_2222);
        chk("flush_wren",  {63'd0, rf_wren_o},  64'd0);
        chk("flush_ready", {63'd0, in_ready_o}, 64'd1);

        // Flush in READY blocks the incoming instruction.
        cyc(1, 2'b00, 5'd11, 1, 3'd0, 32'h5555_5555, 32'h0, 1, 0, 32'h0);
        chk("flush_rdy_retire", {63'd0, retire_o}, 64'd0);
        chk("flush_rdy_instret", instret_o, 64'd8);

        // Reset asserted while a load is outstanding.
        cyc(1, 2'b01, 5'd12, 1, 3'd2, 32'h4000_0000, 32'h0, 0, 0, 32'h0);
        chk_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midrst_ready",   {63'd0, in_ready_o}, 64'd1);
        chk("midrst_instret", instret_o, 64'd0);
        chk("midrst_data",    {32'd0, writeback_data_o}, 64'd0);
        model_reset();
        @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  f3r;
            logic [31:0] alur;
            f3r  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            alur = $urandom;
            if ($urandom_range(0, 1) == 0) alur[1:0] = 2'b00;
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                1'($urandom_range(0, 3) != 0), f3r, alur, $urandom,
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0), $urandom);
        end

        // Drain any pending load, then drive instret4 around a full wrap.
        idle(0, 1, 32'h0);
        for (int i = 0; i < 16 && m_cnt[3:0] != 4'd0; i++) begin
            cyc(1, 2'b00, 5'd3, 1, 3'd0, 32'(i), 32'h0, 0, 0, 32'h0);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1, 2'b00, 5'd4, 1, 3'd0, 32'(i), 32'h0, 0, 0, 32'h0);
        end
        chk("wrap_instret4", {60'd0, instret4}, 64'd0);

        idle(0, 0, 32'h0);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
